// File: rtl/regfile_shift_src.sv
// Three-read / one-write register file (R0..NREGS-1) feeding the operand-2 shifter path.
// Reads of address 15 return the external PC+8 (R15 input). The array is RAM-mapped and
// carries no reset, so after reset an INIT sequencer clears it through the single write
// port, one register per clock. Reads are forced to zero until that sequence finishes.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through on all read ports.
module regfile_shift_src #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      NREGS      = 15,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WE3,
  input  logic [3:0]       WA3,
  input  logic [WIDTH-1:0] WD3,
  input  logic [3:0]       RA1,
  input  logic [3:0]       RA2,
  input  logic [3:0]       RA3,
  input  logic [WIDTH-1:0] R15,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic [WIDTH-1:0] RD3,
  output logic             ready
);

  localparam int unsigned    CntW    = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [4:0]     NRegsA  = 5'(NREGS);
  localparam logic [CntW-1:0] CntLast = CntW'(NREGS - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   init_cnt_q, init_cnt_d;
  logic [WIDTH-1:0]  mem_q [NREGS];

  logic              mem_we;
  logic [3:0]        mem_wa;
  logic [WIDTH-1:0]  mem_wd;

  logic [3:0]        ra [3];
  logic [WIDTH-1:0]  rd [3];

  // Next-state and write-port steering: INIT owns the port, RUN hands it to WE3/WA3/WD3.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_we     = 1'b0;
    mem_wa     = WA3;
    mem_wd     = WD3;
    unique case (state_q)
      StInit: begin
        mem_we = 1'b1;
        mem_wa = 4'(init_cnt_q);
        mem_wd = INIT_VALUE;
        // Counter parks on the last index; it never wraps.
        if (init_cnt_q == CntLast) begin
          state_d = StRun;
        end else begin
          init_cnt_d = init_cnt_q + CntW'(1);
        end
      end
      StRun: begin
        // Writes to 15 (the PC) or beyond the array are dropped.
        mem_we = WE3 && ({1'b0, WA3} < NRegsA);
      end
      default: state_d = StInit;
    endcase
  end

  // State register with synchronous reset back into INIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Array write port; no reset on the storage itself.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign ready = (state_q == StRun);

  assign ra[0] = RA1;
  assign ra[1] = RA2;
  assign ra[2] = RA3;

  // Combinational read ports: zero until ready, R15 for address 15, else array (or bypass).
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd[p] = '0;
      if (ready) begin
        if (ra[p] == 4'hF) begin
          rd[p] = R15;
        end else if ({1'b0, ra[p]} < NRegsA) begin
          rd[p] = mem_q[ra[p]];
        end
`ifdef REGFILE_BYPASS_EN
        if (WE3 && (WA3 == ra[p]) && ({1'b0, WA3} < NRegsA)) begin
          rd[p] = WD3;
        end
`endif
      end
    end
  end

  assign RD1 = rd[0];
  assign RD2 = rd[1];
  assign RD3 = rd[2];

endmodule

// File: tb/tb_regfile_shift_src.sv
// Bench for regfile_shift_src: a behavioural register-file model checked every cycle,
// plus directed vectors with literal expectations.
module tb_regfile_shift_src;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE3;
  logic [3:0]  WA3, RA1, RA2, RA3;
  logic [31:0] WD3, R15;
  logic [31:0] RD1, RD2, RD3;
  logic        ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_shift_src #(
    .WIDTH     (32),
    .NREGS     (15),
    .INIT_VALUE(32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .WE3  (WE3),
    .WA3  (WA3),
    .WD3  (WD3),
    .RA1  (RA1),
    .RA2  (RA2),
    .RA3  (RA3),
    .R15  (R15),
    .RD1  (RD1),
    .RD2  (RD2),
    .RD3  (RD3),
    .ready(ready)
  );

  // Model: count of clean edges since reset; 15 means the clear finished.
  bit          m_valid = 1'b0;
  int          m_cnt   = 0;
  logic [31:0] m_mem [15];

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_cnt   = 0;
    end else if (m_cnt < 15) begin
      m_cnt++;
      if (m_cnt == 15) begin
        for (int i = 0; i < 15; i++) m_mem[i] = 32'h0;
      end
    end else if (WE3 && WA3 != 4'd15) begin
      m_mem[WA3] = WD3;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [3:0] ra);
    if (m_cnt != 15) return 32'h0;
    if (ra == 4'd15) return R15;
`ifdef REGFILE_BYPASS_EN
    if (WE3 && WA3 == ra) return WD3;
`endif
    return m_mem[ra];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_ready", 32'(ready), (m_cnt == 15) ? 32'h1 : 32'h0);
      check("model_rd1", RD1, exp_rd(RA1));
      check("model_rd2", RD2, exp_rd(RA2));
      check("model_rd3", RD3, exp_rd(RA3));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sh;

  initial begin
    reset = 1'b1; WE3 = 1'b0; WA3 = '0; WD3 = '0;
    RA1 = '0; RA2 = '0; RA3 = '0; R15 = '0;
    tick();
    tick();
    reset = 1'b0;
    #1 check("reset_ready", 32'(ready), 32'h0);

    // INIT: 15 edges, a user write attempted on edge 3 must not land.
    for (int i = 0; i < 15; i++) begin
      check("init_not_ready", 32'(ready), 32'h0);
      if (i == 2) begin
        WE3 = 1'b1; WA3 = 4'd5; WD3 = 32'h55;
      end else begin
        WE3 = 1'b0;
      end
      tick();
    end
    WE3 = 1'b0;
    RA1 = 4'd3; RA3 = 4'd5;
    #1;
    check("ready_after_15", 32'(ready), 32'h1);
    check("r3_cleared", RD1, 32'h0);
    check("init_write_dropped", RD3, 32'h0);

    // Write R4, same-cycle and next-cycle read on port 2.
    WE3 = 1'b1; WA3 = 4'd4; WD3 = 32'hDEADBEEF; RA2 = 4'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_rd2", RD2, 32'hDEADBEEF);
`else
    check("same_cycle_rd2", RD2, 32'h0);
`endif
    tick();
    WE3 = 1'b0;
    #1 check("next_cycle_rd2", RD2, 32'hDEADBEEF);

    // R15 reads the PC; writes to 15 are dropped.
    R15 = 32'h108; RA1 = 4'd15;
    #1 check("r15_read", RD1, 32'h108);
    WE3 = 1'b1; WA3 = 4'd15; WD3 = 32'hFFFFFFFF;
    #1 check("r15_no_bypass", RD1, 32'h108);
    tick();
    WE3 = 1'b0;
    #1 check("r15_after_write", RD1, 32'h108);
    for (int r = 0; r < 15; r++) begin
      RA3 = 4'(r);
      #1 check("regs_unchanged", RD3, (r == 4) ? 32'hDEADBEEF : 32'h0);
      tick();
    end

    // Highest array index.
    WE3 = 1'b1; WA3 = 4'd14; WD3 = 32'hCAFEF00D;
    tick();
    WE3 = 1'b0; RA1 = 4'd14;
    #1 check("r14_rw", RD1, 32'hCAFEF00D);

    // Three ports into the shifter: LSR by register.
    WE3 = 1'b1; WA3 = 4'd1; WD3 = 32'h4;
    tick();
    WA3 = 4'd2; WD3 = 32'h80000001;
    tick();
    WE3 = 1'b0; RA1 = 4'd1; RA2 = 4'd2; RA3 = 4'd2;
    #1;
    check("rs_read", RD1, 32'h4);
    check("rm_read", RD2, 32'h80000001);
    check("rd_read", RD3, 32'h80000001);
    sh = RD2 >> RD1[7:0];
    check("lsr_result", sh, 32'h08000000);

    // All ports on one register during its write.
    RA1 = 4'd2;
    WE3 = 1'b1; WA3 = 4'd2; WD3 = 32'h0000A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("triple_same_cycle", RD3, 32'h0000A5A5);
`else
    check("triple_same_cycle", RD3, 32'h80000001);
`endif
    tick();
    WE3 = 1'b0;
    #1 check("triple_after", RD1, 32'h0000A5A5);

    // Reset mid-INIT restarts the full 15-edge clear.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("midinit_not_ready", 32'(ready), 32'h0);
      tick();
    end
    #1 check("midinit_ready", 32'(ready), 32'h1);

    // Reset mid-RUN wipes R7.
    WE3 = 1'b1; WA3 = 4'd7; WD3 = 32'h12345678;
    tick();
    WE3 = 1'b0; RA1 = 4'd7; RA2 = 4'd15;
    #1 check("r7_written", RD1, 32'h12345678);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("run_reset_ready", 32'(ready), 32'h0);
    check("run_reset_rd1", RD1, 32'h0);
    check("init_r15_zero", RD2, 32'h0);
    for (int i = 0; i < 15; i++) begin
      check("rerun_not_ready", 32'(ready), 32'h0);
      tick();
    end
    #1;
    check("rerun_ready", 32'(ready), 32'h1);
    check("r7_lost", RD1, 32'h0);
    check("r15_back", RD2, 32'h108);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
